// File: rtl/elastic_shift_register_hs.sv
// elastic_shift_register_hs
//   A DEPTH-stage data/valid delay line with ready/valid flow control on every
//   stage. While downstream is ready, every word takes exactly DEPTH cycles to
//   pass through. Under backpressure the stall reaches back only as far as the
//   first empty stage, so words behind it keep moving and fill the bubbles.
//   A synchronous flush clears all valids. The data registers are left alone.
//   count tracks how many stages currently hold a valid word.
// Ports
//   clk        clock, all logic on posedge
//   rst_n      synchronous reset, ACTIVE-HIGH (1 = reset) despite the name
//   flush      synchronous clear of all stage valids
//   in_valid   upstream word valid
//   in_ready   block accepts in_data this cycle
//   in_data    upstream word [WIDTH]
//   out_valid  last stage valid
//   out_ready  downstream accepts out_data this cycle
//   out_data   last stage data [WIDTH]
//   count      number of valid stages, 0..DEPTH [CNT_W]

// One stage: holds {v,d} unless told to load from its predecessor.
module esr_stage #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  always_ff @(posedge clk) begin
    if (rst || flush) v <= 1'b0;
    else if (load)    v <= v_in;
  end

  // Data is never reset. It is a don't-care whenever v is low.
  always_ff @(posedge clk) begin
    if (load) d <= d_in;
  end
endmodule

module elastic_shift_register_hs #(
  parameter  int WIDTH = 256,
  parameter  int DEPTH = 10,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);
  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic                        accept;
  logic                        emit;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      // Unrolled form of rdy[k] = !v[k] | rdy[k+1]. A stage can move when
      // downstream is ready or when any stage from here to the output is empty.
      // This form depends only on registered valids, so rdy never feeds itself.
      assign rdy[k] = out_ready | ~(&v[DEPTH-1:k]);

      if (k == 0) begin : g_head
        esr_stage #(.WIDTH(WIDTH)) u_stage (
          .clk   (clk),
          .rst   (rst_n),
          .flush (flush),
          .load  (rdy[0]),
          .v_in  (in_valid),
          .d_in  (in_data),
          .v     (v[0]),
          .d     (d[0])
        );
      end else begin : g_body
        esr_stage #(.WIDTH(WIDTH)) u_stage (
          .clk   (clk),
          .rst   (rst_n),
          .flush (flush),
          .load  (rdy[k]),
          .v_in  (v[k-1]),
          .d_in  (d[k-1]),
          .v     (v[k]),
          .d     (d[k])
        );
      end
    end
  endgenerate

  assign in_ready  = rdy[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign accept    = in_valid & rdy[0];
  assign emit      = v[DEPTH-1] & out_ready;

  // The count follows the handshakes, so it always equals popcount(v).
  // A simultaneous accept and emit leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst_n || flush)       count <= '0;
    else if (accept && !emit) count <= count + CNT_W'(1);
    else if (emit && !accept) count <= count - CNT_W'(1);
  end
endmodule

// File: tb/tb_elastic_shift_register_hs.sv
module tb_elastic_shift_register_hs;
  localparam int WIDTH = 256;
  localparam int DEPTH = 10;
  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef logic [WIDTH-1:0] word_t;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  word_t            in_data, out_data;
  logic [CNT_W-1:0] count;

  elastic_shift_register_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  word_t q[$];
  logic  known = 1'b0;
  logic  hold  = 1'b0;
  word_t hold_d;
  logic  cur_fl, cur_rs;

  typedef struct {
    logic iv;
    logic ordy;
    logic exp_ir;
    int   exp_cnt;
    logic exp_ov;
  } vec_t;
  vec_t vecs[18];

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then at the negedge check the model and do the
  // scoreboard bookkeeping for the handshakes that happen at the next edge.
  task automatic half1(input logic iv, input logic ordy, input logic fl,
                       input logic rs, input word_t dat);
    logic  exp_ir;
    word_t expw;
    in_valid = iv; out_ready = ordy; flush = fl; rst_n = rs; in_data = dat;
    cur_fl = fl; cur_rs = rs;
    @(negedge clk);
    if (known) begin
      exp_ir = ordy || (q.size() < DEPTH);
      chk("count", word_t'(count), word_t'(q.size()));
      chk("in_ready", word_t'(in_ready), word_t'(exp_ir));
      if (hold) begin
        chk("hold_valid", word_t'(out_valid), word_t'(1));
        chk("hold_data", out_data, hold_d);
      end
      if (q.size() == 0) chk("valid_when_empty", word_t'(out_valid), word_t'(0));
      if (!rs && ordy && out_valid === 1'b1 && q.size() > 0) begin
        expw = q.pop_front();
        chk("out_data", out_data, expw);
      end
      if (!rs && !fl && iv && exp_ir) q.push_back(dat);
      hold   = (out_valid === 1'b1) && !ordy && !fl && !rs;
      hold_d = out_data;
    end
  endtask

  task automatic half2();
    @(posedge clk);
    #1;
    if (cur_rs || cur_fl) begin
      q.delete();
      hold = 1'b0;
    end
    if (cur_rs) known = 1'b1;
  endtask

  task automatic step(input logic iv, input logic ordy, input logic fl,
                      input logic rs, input word_t dat);
    half1(iv, ordy, fl, rs, dat);
    half2();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic post_reset_chk(input string tag);
    out_ready = 1'b0; in_valid = 1'b0; rst_n = 1'b0; flush = 1'b0;
    #1;
    chk({tag, "_out_valid"}, word_t'(out_valid), word_t'(0));
    chk({tag, "_in_ready"},  word_t'(in_ready),  word_t'(1));
    chk({tag, "_count"},     word_t'(count),     word_t'(0));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Fill with out_ready low, then release: the state is fixed per cycle.
    for (int i = 0; i < 18; i++) begin
      vecs[i].iv      = 1'b1;
      vecs[i].ordy    = (i >= 12);
      vecs[i].exp_ir  = (i < 10) || (i >= 12);
      vecs[i].exp_cnt = (i < 10) ? i : 10;
      vecs[i].exp_ov  = (i >= 10);
    end

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    post_reset_chk("reset");

    // 1: steady stream, latency and ordering
    for (int i = 0; i < 30; i++) begin
      half1(i < 20, 1'b1, 1'b0, 1'b0, word_t'(i + 1));
      chk("t1_out_valid", word_t'(out_valid), word_t'(i >= 10));
      half2();
    end

    // 2: fill while stalled, then full throughput
    do_reset();
    for (int i = 0; i < 18; i++) begin
      half1(vecs[i].iv, vecs[i].ordy, 1'b0, 1'b0, word_t'(i + 1));
      chk("t2_in_ready",  word_t'(in_ready),  word_t'(vecs[i].exp_ir));
      chk("t2_count",     word_t'(count),     word_t'(vecs[i].exp_cnt));
      chk("t2_out_valid", word_t'(out_valid), word_t'(vecs[i].exp_ov));
      half2();
    end
    drain(15);

    // 3: bubbly input under stall compacts without loss
    do_reset();
    for (int i = 0; i < 15; i++)
      step(i % 3 == 0, 1'b0, 1'b0, 1'b0, word_t'(32'hA0 + i / 3));
    chk("t3_count", word_t'(count), word_t'(5));
    drain(20);
    chk("t3_drained", word_t'(q.size()), word_t'(0));

    // 4: flush with 6 words held drops them and the flush-cycle word
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, word_t'(32'h40 + i));
    step(1'b1, 1'b0, 1'b1, 1'b0, word_t'(32'h55));
    half1(1'b1, 1'b1, 1'b0, 1'b0, word_t'(32'h77));
    chk("t4_flush_valid", word_t'(out_valid), word_t'(0));
    chk("t4_flush_count", word_t'(count),     word_t'(0));
    half2();
    for (int j = 1; j <= 10; j++) begin
      half1(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("t4_latency", word_t'(out_valid), word_t'(j == 10));
      half2();
    end
    drain(3);

    // 5: reset while full and stalled
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0, word_t'(32'h900 + i));
    chk("t5_full", word_t'(count), word_t'(DEPTH));
    do_reset();
    post_reset_chk("t5");
    drain(15);

    // 6: random traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 10000; i++)
      step($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, 1'b0, 1'b0,
           {8{$urandom()}});
    drain(DEPTH + 5);
    chk("t6_drained", word_t'(q.size()), word_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
